// File: rtl/megarom_pkg.sv
// Shared constants, state encoding and address helpers for the MegaROM mapper.
package megarom_pkg;

  localparam int unsigned NUM_BANKS = 4;
  localparam logic [15:0] WIN_LO    = 16'h4000;
  localparam logic [15:0] WIN_HI    = 16'hC000;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_RD_REQ  = 3'd1;
  localparam state_t ST_RD_HOLD = 3'd2;
  localparam state_t ST_WR_REQ  = 3'd3;
  localparam state_t ST_WR_HOLD = 3'd4;

  // 8K mode: 4000h->0, 6000h->1, 8000h->2, A000h->3; 16K mode: 4000h->0, 8000h->1
  function automatic logic [1:0] bank_sel(input logic [15:0] addr, input logic mode16k);
    return mode16k ? {1'b0, addr[15]} : (addr[14:13] ^ 2'b10);
  endfunction

  function automatic logic [21:0] bank_offset(input logic [7:0] bank, input logic [15:0] addr,
                                              input logic mode16k);
    return mode16k ? {bank, addr[13:0]} : {1'b0, bank, addr[12:0]};
  endfunction

endpackage

// File: rtl/megarom_bank_regs.sv
// Four bank registers: masked-address match write, init load on either reset.
module megarom_bank_regs
  import megarom_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET_n,
  input  logic        bus_rst_i,
  input  logic        wr_stb_i,
  input  logic [15:0] addr_i,
  input  logic [7:0]  din_i,
  input  logic [63:0] cfg_bank_addr_i,
  input  logic [31:0] cfg_bank_init_i,
  input  logic [15:0] cfg_addr_mask_i,
  input  logic [7:0]  cfg_data_mask_i,
  output logic [31:0] bank_o
);

  logic [NUM_BANKS-1:0][7:0] bank_q, bank_d;

  always_comb begin
    bank_d = bank_q;
    if (bus_rst_i) begin
      bank_d = cfg_bank_init_i;
    end else if (wr_stb_i) begin
      // every matching register loads, so aliased bank addresses all update
      for (int unsigned i = 0; i < NUM_BANKS; i++) begin
        if (((addr_i ^ cfg_bank_addr_i[16*i +: 16]) & ~cfg_addr_mask_i) == '0) begin
          bank_d[i] = din_i & cfg_data_mask_i;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      bank_q <= cfg_bank_init_i;
    end else begin
      bank_q <= bank_d;
    end
  end

  assign bank_o = bank_q;

endmodule

// File: rtl/megarom_bank_controller.sv
// MegaROM slot mapper: bus decode, bank translation and one RAM REQ/ACK cycle per bus access.
module megarom_bank_controller
  import megarom_pkg::*;
#(
  parameter int unsigned RAM_ADDR_W = 24,
  parameter int unsigned RAM_TOP    = 0
) (
  input  logic                  CLK,
  input  logic                  RESET_n,
  input  logic                  BUS_RESET_n,
  input  logic                  SLTSL_n,
  input  logic                  MERQ_n,
  input  logic                  RD_n,
  input  logic                  WR_n,
  input  logic [15:0]           ADDR,
  input  logic [7:0]            DIN,
  output logic [7:0]            DOUT,
  output logic                  BUSDIR_n,
  output logic                  WAIT_n,
  input  logic [63:0]           CFG_BANK_ADDR,
  input  logic [31:0]           CFG_BANK_INIT,
  input  logic [15:0]           CFG_ADDR_MASK,
  input  logic [7:0]            CFG_DATA_MASK,
  input  logic                  CFG_WP,
  input  logic                  CFG_16K,
  input  logic                  CFG_CS1_MASK,
  input  logic                  CFG_CS2_MASK,
  output logic                  MEM_REQ,
  output logic                  MEM_WE,
  output logic [RAM_ADDR_W-1:0] MEM_ADDR,
  output logic [7:0]            MEM_WDATA,
  input  logic                  MEM_ACK,
  input  logic [7:0]            MEM_RDATA,
  output logic [31:0]           BANK
);

  logic rd_n, wr_n, rd_n_q, wr_n_q, det_rd, det_wr, bus_rst;
  logic win, masked, visible, abort_now;
  logic [1:0] sel;
  logic [7:0] sel_bank;
  logic [RAM_ADDR_W-1:0] addr_calc;

  state_t                state_q, state_d;
  logic                  mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [RAM_ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]            mem_wdata_q, mem_wdata_d, dout_q, dout_d;
  logic                  busdir_n_q, busdir_n_d, wait_n_q, wait_n_d, abort_q, abort_d;

  assign rd_n    = SLTSL_n | MERQ_n | RD_n;
  assign wr_n    = SLTSL_n | MERQ_n | WR_n;
  assign det_rd  = rd_n_q & ~rd_n;
  assign det_wr  = wr_n_q & ~wr_n;
  assign bus_rst = ~BUS_RESET_n;

  assign win     = (ADDR >= WIN_LO) && (ADDR < WIN_HI);
  assign masked  = ADDR[15] ? CFG_CS2_MASK : CFG_CS1_MASK;
  assign visible = win & ~masked;

  megarom_bank_regs u_bank_regs (
    .CLK             (CLK),
    .RESET_n         (RESET_n),
    .bus_rst_i       (bus_rst),
    .wr_stb_i        (det_wr),
    .addr_i          (ADDR),
    .din_i           (DIN),
    .cfg_bank_addr_i (CFG_BANK_ADDR),
    .cfg_bank_init_i (CFG_BANK_INIT),
    .cfg_addr_mask_i (CFG_ADDR_MASK),
    .cfg_data_mask_i (CFG_DATA_MASK),
    .bank_o          (BANK)
  );

  // BANK is the registered value, so a same-cycle bank write does not affect this address
  assign sel       = bank_sel(ADDR, CFG_16K);
  assign sel_bank  = BANK[8*sel +: 8];
  assign addr_calc = RAM_ADDR_W'(RAM_TOP) + RAM_ADDR_W'(bank_offset(sel_bank, ADDR, CFG_16K));

  // A request whose bus cycle was reset or abandoned must still finish its handshake
  assign abort_now = abort_q | bus_rst |
                     ((state_q == ST_RD_REQ) & rd_n) |
                     ((state_q == ST_WR_REQ) & wr_n);

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    dout_d      = dout_q;
    busdir_n_d  = busdir_n_q;
    wait_n_d    = wait_n_q;
    abort_d     = abort_q;

    if ((state_q == ST_RD_REQ) || (state_q == ST_WR_REQ)) begin
      if (bus_rst) begin
        wait_n_d   = 1'b1;
        busdir_n_d = 1'b1;
        dout_d     = '0;
      end
      if (MEM_ACK) begin
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
        wait_n_d  = 1'b1;
        abort_d   = 1'b0;
        if (abort_now) begin
          state_d     = ST_IDLE;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
        end else if (state_q == ST_RD_REQ) begin
          state_d    = ST_RD_HOLD;
          dout_d     = MEM_RDATA;
          busdir_n_d = 1'b0;
        end else begin
          state_d = ST_WR_HOLD;
        end
      end else begin
        abort_d = abort_now;
      end
    end else if (bus_rst) begin
      state_d     = ST_IDLE;
      mem_req_d   = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = '0;
      mem_wdata_d = '0;
      dout_d      = '0;
      busdir_n_d  = 1'b1;
      wait_n_d    = 1'b1;
      abort_d     = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (det_rd && visible) begin
            state_d    = ST_RD_REQ;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = addr_calc;
            wait_n_d   = 1'b0;
          end else if (det_wr && visible && !CFG_WP) begin
            state_d     = ST_WR_REQ;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = addr_calc;
            mem_wdata_d = DIN;
            wait_n_d    = 1'b0;
          end
        end
        ST_RD_HOLD: begin
          if (rd_n) begin
            state_d    = ST_IDLE;
            busdir_n_d = 1'b1;
            dout_d     = '0;
          end
        end
        ST_WR_HOLD: begin
          if (wr_n) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      dout_q      <= '0;
      busdir_n_q  <= 1'b1;
      wait_n_q    <= 1'b1;
      abort_q     <= 1'b0;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      dout_q      <= dout_d;
      busdir_n_q  <= busdir_n_d;
      wait_n_q    <= wait_n_d;
      abort_q     <= abort_d;
      rd_n_q      <= rd_n;
      wr_n_q      <= wr_n;
    end
  end

  assign MEM_REQ   = mem_req_q;
  assign MEM_WE    = mem_we_q;
  assign MEM_ADDR  = mem_addr_q;
  assign MEM_WDATA = mem_wdata_q;
  assign DOUT      = dout_q;
  assign BUSDIR_n  = busdir_n_q;
  assign WAIT_n    = wait_n_q;

endmodule

// File: tb/tb_megarom_bank_controller.sv
// Bench: directed plus random bus cycles against a window-arithmetic reference of the mapper.
module tb_megarom_bank_controller;

  localparam int unsigned TOP_A = 32'h100000;
  localparam int unsigned TOP_B = 32'hFFE000;

  logic        CLK = 1'b0;
  logic        RESET_n, BUS_RESET_n, SLTSL_n, MERQ_n, RD_n, WR_n;
  logic [15:0] ADDR;
  logic [7:0]  DIN;
  logic [63:0] CFG_BANK_ADDR;
  logic [31:0] CFG_BANK_INIT;
  logic [15:0] CFG_ADDR_MASK;
  logic [7:0]  CFG_DATA_MASK;
  logic        CFG_WP, CFG_16K, CFG_CS1_MASK, CFG_CS2_MASK;
  logic        MEM_ACK;
  logic [7:0]  MEM_RDATA;

  logic [7:0]  dout, w_dout;
  logic        busdir_n, wait_n, mem_req, mem_we;
  logic        w_busdir_n, w_wait_n, w_mem_req, w_mem_we;
  logic [23:0] mem_addr, w_mem_addr;
  logic [7:0]  mem_wdata, w_mem_wdata;
  logic [31:0] bank, w_bank;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  logic [7:0]  m_bank [4];

  always #5 CLK = ~CLK;

  megarom_bank_controller #(.RAM_ADDR_W(24), .RAM_TOP(TOP_A)) u_dut (
    .CLK(CLK), .RESET_n(RESET_n), .BUS_RESET_n(BUS_RESET_n),
    .SLTSL_n(SLTSL_n), .MERQ_n(MERQ_n), .RD_n(RD_n), .WR_n(WR_n),
    .ADDR(ADDR), .DIN(DIN), .DOUT(dout), .BUSDIR_n(busdir_n), .WAIT_n(wait_n),
    .CFG_BANK_ADDR(CFG_BANK_ADDR), .CFG_BANK_INIT(CFG_BANK_INIT),
    .CFG_ADDR_MASK(CFG_ADDR_MASK), .CFG_DATA_MASK(CFG_DATA_MASK),
    .CFG_WP(CFG_WP), .CFG_16K(CFG_16K), .CFG_CS1_MASK(CFG_CS1_MASK), .CFG_CS2_MASK(CFG_CS2_MASK),
    .MEM_REQ(mem_req), .MEM_WE(mem_we), .MEM_ADDR(mem_addr), .MEM_WDATA(mem_wdata),
    .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA), .BANK(bank)
  );

  megarom_bank_controller #(.RAM_ADDR_W(24), .RAM_TOP(TOP_B)) u_wrap (
    .CLK(CLK), .RESET_n(RESET_n), .BUS_RESET_n(BUS_RESET_n),
    .SLTSL_n(SLTSL_n), .MERQ_n(MERQ_n), .RD_n(RD_n), .WR_n(WR_n),
    .ADDR(ADDR), .DIN(DIN), .DOUT(w_dout), .BUSDIR_n(w_busdir_n), .WAIT_n(w_wait_n),
    .CFG_BANK_ADDR(CFG_BANK_ADDR), .CFG_BANK_INIT(CFG_BANK_INIT),
    .CFG_ADDR_MASK(CFG_ADDR_MASK), .CFG_DATA_MASK(CFG_DATA_MASK),
    .CFG_WP(CFG_WP), .CFG_16K(CFG_16K), .CFG_CS1_MASK(CFG_CS1_MASK), .CFG_CS2_MASK(CFG_CS2_MASK),
    .MEM_REQ(w_mem_req), .MEM_WE(w_mem_we), .MEM_ADDR(w_mem_addr), .MEM_WDATA(w_mem_wdata),
    .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA), .BANK(w_bank)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] model_bank();
    return {m_bank[3], m_bank[2], m_bank[1], m_bank[0]};
  endfunction

  function automatic void model_init();
    for (int i = 0; i < 4; i++) m_bank[i] = CFG_BANK_INIT[8*i +: 8];
  endfunction

  function automatic bit ref_visible(input int unsigned a);
    if (a < 32'h4000 || a >= 32'hC000) return 1'b0;
    return (a < 32'h8000) ? !CFG_CS1_MASK : !CFG_CS2_MASK;
  endfunction

  // Window is split into equal pages from 4000h; page index picks the bank
  function automatic logic [23:0] ref_addr(input int unsigned top, input int unsigned a);
    int unsigned size, idx, off;
    size = CFG_16K ? 16384 : 8192;
    idx  = (a - 32'h4000) / size;
    off  = a % size;
    return 24'((top + m_bank[idx] * size + off) % (1 << 24));
  endfunction

  function automatic void ref_bank_write(input int unsigned a, input logic [7:0] d);
    for (int i = 0; i < 4; i++)
      if (((a ^ CFG_BANK_ADDR[16*i +: 16]) & ~CFG_ADDR_MASK & 32'hFFFF) == 0)
        m_bank[i] = d & CFG_DATA_MASK;
  endfunction

  task automatic release_bus();
    SLTSL_n = 1'b1; MERQ_n = 1'b1; RD_n = 1'b1; WR_n = 1'b1;
  endtask

  task automatic do_read(input logic [15:0] a, input int unsigned d, input logic [7:0] rd);
    bit vis;
    logic [23:0] ea, eb;
    int unsigned wl;
    vis = ref_visible(a);
    ea  = ref_addr(TOP_A, a);
    eb  = ref_addr(TOP_B, a);
    @(negedge CLK);
    ADDR = a; SLTSL_n = 1'b0; MERQ_n = 1'b0; RD_n = 1'b0;
    @(negedge CLK);
    check("rd_req", mem_req, vis);
    if (vis) begin
      check("rd_addr", mem_addr, ea);
      check("rd_addr_wrap", w_mem_addr, eb);
      check("rd_we", mem_we, 0);
      wl = 0;
      for (int i = 0; i < int'(d); i++) begin
        if (!wait_n) wl++;
        @(negedge CLK);
      end
      if (!wait_n) wl++;
      MEM_ACK = 1'b1; MEM_RDATA = rd;
      @(negedge CLK);
      MEM_ACK = 1'b0; MEM_RDATA = 8'($urandom);
      check("rd_wait_cycles", wl, d + 1);
      check("rd_dout", dout, rd);
      check("rd_busdir", busdir_n, 0);
      check("rd_wait_release", wait_n, 1);
      check("rd_req_drop", mem_req, 0);
    end else begin
      repeat (2) @(negedge CLK);
      check("rd_hidden_req", mem_req, 0);
      check("rd_hidden_busdir", busdir_n, 1);
      check("rd_hidden_wait", wait_n, 1);
    end
    release_bus();
    @(negedge CLK);
    check("rd_end_busdir", busdir_n, 1);
    check("rd_end_dout", dout, 0);
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] dv, input int unsigned d);
    bit vis;
    logic [23:0] ea;
    vis = ref_visible(a) && !CFG_WP;
    ea  = ref_addr(TOP_A, a);
    @(negedge CLK);
    ADDR = a; DIN = dv; SLTSL_n = 1'b0; MERQ_n = 1'b0; WR_n = 1'b0;
    @(negedge CLK);
    ref_bank_write(a, dv);
    check("wr_req", mem_req, vis);
    check("wr_bank", bank, model_bank());
    if (vis) begin
      check("wr_we", mem_we, 1);
      check("wr_wdata", mem_wdata, dv);
      check("wr_addr", mem_addr, ea);
      check("wr_wait", wait_n, 0);
      repeat (d) @(negedge CLK);
      MEM_ACK = 1'b1;
      @(negedge CLK);
      MEM_ACK = 1'b0;
      check("wr_req_drop", mem_req, 0);
      check("wr_wait_release", wait_n, 1);
    end else begin
      @(negedge CLK);
      check("wr_hidden_wait", wait_n, 1);
    end
    check("wr_busdir", busdir_n, 1);
    release_bus();
    @(negedge CLK);
  endtask

  initial begin
    RESET_n = 1'b0; BUS_RESET_n = 1'b1;
    release_bus();
    ADDR = '0; DIN = '0; MEM_ACK = 1'b0; MEM_RDATA = '0;
    CFG_BANK_INIT = 32'h03020100;
    CFG_BANK_ADDR = {16'hB000, 16'h9000, 16'h7000, 16'h5000};
    CFG_ADDR_MASK = 16'h0000; CFG_DATA_MASK = 8'hFF;
    CFG_WP = 1'b0; CFG_16K = 1'b0; CFG_CS1_MASK = 1'b0; CFG_CS2_MASK = 1'b0;
    model_init();
    repeat (3) @(negedge CLK);
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wait", wait_n, 1);
    check("rst_busdir", busdir_n, 1);
    check("rst_dout", dout, 0);
    check("rst_bank", bank, 32'h03020100);
    RESET_n = 1'b1;
    @(negedge CLK);

    // 8K read through bank1 with a three-cycle ACK delay
    do_read(16'h6123, 3, 8'hA5);

    // masked-address bank write, then read through the new bank
    CFG_ADDR_MASK = 16'h07FF; CFG_DATA_MASK = 8'h1F;
    do_write(16'h97FF, 8'hE5, 1);
    check("bank2_masked", bank[23:16], 8'h05);
    do_read(16'h8000, 0, 8'h3C);

    // 16K mode with upper half disabled
    CFG_16K = 1'b1; CFG_CS2_MASK = 1'b1;
    do_read(16'hA000, 0, 8'h11);
    do_read(16'h4000, 1, 8'h22);
    CFG_CS2_MASK = 1'b0;

    // write protect suppresses the RAM cycle
    CFG_WP = 1'b1;
    do_write(16'h4000, 8'h77, 0);
    CFG_WP = 1'b0;
    do_write(16'h4000, 8'h3C, 2);

    // bus reset while a read request is outstanding
    @(negedge CLK);
    ADDR = 16'h4000; SLTSL_n = 1'b0; MERQ_n = 1'b0; RD_n = 1'b0;
    @(negedge CLK);
    check("brst_req_start", mem_req, 1);
    BUS_RESET_n = 1'b0;
    @(negedge CLK);
    BUS_RESET_n = 1'b1;
    model_init();
    check("brst_req_held", mem_req, 1);
    check("brst_wait", wait_n, 1);
    check("brst_bank", bank, model_bank());
    @(negedge CLK);
    check("brst_req_still", mem_req, 1);
    MEM_ACK = 1'b1; MEM_RDATA = 8'h99;
    @(negedge CLK);
    MEM_ACK = 1'b0;
    check("brst_req_drop", mem_req, 0);
    check("brst_busdir", busdir_n, 1);
    check("brst_dout", dout, 0);
    @(negedge CLK);
    check("brst_idle_req", mem_req, 0);
    check("brst_idle_busdir", busdir_n, 1);
    release_bus();
    @(negedge CLK);

    // strobe released before ACK: request completes, no data phase
    CFG_16K = 1'b0;
    @(negedge CLK);
    ADDR = 16'h6000; SLTSL_n = 1'b0; MERQ_n = 1'b0; RD_n = 1'b0;
    @(negedge CLK);
    check("abort_req_start", mem_req, 1);
    release_bus();
    @(negedge CLK);
    check("abort_req_held", mem_req, 1);
    MEM_ACK = 1'b1; MEM_RDATA = 8'h5A;
    @(negedge CLK);
    MEM_ACK = 1'b0;
    check("abort_req_drop", mem_req, 0);
    check("abort_busdir", busdir_n, 1);
    @(negedge CLK);
    check("abort_busdir_idle", busdir_n, 1);
    check("abort_dout", dout, 0);

    // bank0 = FFh so the FFE000h-based instance wraps past 2^24
    CFG_ADDR_MASK = 16'h0000; CFG_DATA_MASK = 8'hFF;
    do_write(16'h5000, 8'hFF, 0);
    check("wrap_bank0", bank[7:0], 8'hFF);
    do_read(16'h4000, 0, 8'h42);
    @(negedge CLK);
    ADDR = 16'h4000; SLTSL_n = 1'b0; MERQ_n = 1'b0; RD_n = 1'b0;
    @(negedge CLK);
    check("wrap_addr_const", w_mem_addr, 24'h1FC000);
    MEM_ACK = 1'b1;
    @(negedge CLK);
    MEM_ACK = 1'b0;
    release_bus();
    @(negedge CLK);

    for (int it = 0; it < 40; it++) begin
      logic [15:0] a;
      if ($urandom_range(3) == 0) begin
        CFG_16K       = 1'($urandom);
        CFG_WP        = ($urandom_range(3) == 0);
        CFG_CS1_MASK  = ($urandom_range(4) == 0);
        CFG_CS2_MASK  = ($urandom_range(4) == 0);
        CFG_ADDR_MASK = 16'($urandom) & 16'h0FFF;
        CFG_DATA_MASK = 8'($urandom);
      end
      if ($urandom_range(1) == 0)
        a = CFG_BANK_ADDR[16*$urandom_range(3) +: 16] ^ (16'($urandom) & CFG_ADDR_MASK);
      else
        a = 16'($urandom);
      if ($urandom_range(1) == 0) do_read(a, $urandom_range(3), 8'($urandom));
      else                        do_write(a, 8'($urandom), $urandom_range(3));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
